// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: MDU funct codes,
// FSM encoding and the ID/EX NOP control word.
package pipe_hazard_ctrl_pkg;

    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_t;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic mdu_op;
    } idex_ctrl_t;

    // Control word the ID/EX register loads when idex_bubble is high.
    localparam idex_ctrl_t IDEX_NOP = '0;

    function automatic logic is_mdu_op(input logic rtype, input logic [5:0] funct);
        return rtype & ((funct == FUNCT_MULTU) | (funct == FUNCT_DIVU));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-information inputs and pipeline-control outputs of the hazard controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_memread;
    logic [4:0]       ex_rt;
    logic             ex_rtype;
    logic [5:0]       ex_funct;
    logic             ex_redirect;

    logic             pc_we;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic             mdu_start;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cycles;

    // master: the hazard controller, driving the pipeline enables
    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_rtype, ex_funct, ex_redirect,
        output pc_we, ifid_en, ifid_flush, idex_en, idex_bubble, mdu_start, mdu_busy,
               stall_cycles
    );

    // slave: the pipeline datapath, reporting hazards and obeying the enables
    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_memread, ex_rt, ex_rtype, ex_funct, ex_redirect,
        input  pc_we, ifid_en, ifid_flush, idex_en, idex_bubble, mdu_start, mdu_busy,
               stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_mdu_timer.sv
// Loadable down-counter timing the front-end freeze for MULTU/DIVU.
module mdu_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use stall, redirect flush,
// fixed-latency MDU freeze and a saturating stall-cycle counter.
//
// state   | meaning
// ST_RUN  | normal flow; load-use / redirect / MDU start evaluated
// ST_MDU  | front end frozen while the MDU timer runs down; release at zero
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.master bus
);
    localparam int            TW       = $clog2(MDU_CYCLES);
    localparam logic [TW-1:0] MDU_LOAD = TW'(MDU_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] stall_q;
    logic             ex_mdu;
    logic             load_use;
    logic             timer_load;
    logic             timer_dec;
    logic             timer_zero;
    logic             pc_we;

    assign ex_mdu   = is_mdu_op(bus.ex_rtype, bus.ex_funct);
    assign load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                      ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    mdu_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (MDU_LOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    always_comb begin
        pc_we           = 1'b1;
        bus.ifid_en     = 1'b1;
        bus.idex_en     = 1'b1;
        bus.ifid_flush  = 1'b0;
        bus.idex_bubble = 1'b0;
        bus.mdu_start   = 1'b0;
        bus.mdu_busy    = 1'b0;
        timer_load      = 1'b0;
        timer_dec       = 1'b0;
        if (!rst) begin
            pc_we           = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_en     = 1'b0;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (state == ST_MDU) begin
            // release cycle keeps the RUN defaults; hazards are ignored throughout
            if (!timer_zero) begin
                pc_we        = 1'b0;
                bus.ifid_en  = 1'b0;
                bus.idex_en  = 1'b0;
                bus.mdu_busy = 1'b1;
                timer_dec    = 1'b1;
            end
        end else if (ex_mdu) begin
            pc_we         = 1'b0;
            bus.ifid_en   = 1'b0;
            bus.idex_en   = 1'b0;
            bus.mdu_start = 1'b1;
            bus.mdu_busy  = 1'b1;
            timer_load    = 1'b1;
        end else if (bus.ex_redirect) begin
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_we           = 1'b0;
            bus.ifid_en     = 1'b0;
            bus.idex_bubble = 1'b1;
        end
    end

    assign bus.pc_we = pc_we;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:  if (ex_mdu) state <= ST_MDU;
                ST_MDU:  if (timer_zero) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (!pc_we && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a default instance plus a CNT_W=4 instance
// for counter saturation; expectations are queued and popped at each sample point.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(16)) if_a ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  if_b ();

    pipe_hazard_ctrl #(.MDU_CYCLES(32), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if_a)
    );

    pipe_hazard_ctrl #(.MDU_CYCLES(32), .CNT_W(4)) dut_w4 (
        .clk (clk),
        .rst (rst),
        .bus (if_b)
    );

    // {pc_we, ifid_en, ifid_flush, idex_en, idex_bubble, mdu_start, mdu_busy}
    localparam logic [6:0] C_RESET  = 7'b0010100;
    localparam logic [6:0] C_RUN    = 7'b1101000;
    localparam logic [6:0] C_LDUSE  = 7'b0001100;
    localparam logic [6:0] C_REDIR  = 7'b1111100;
    localparam logic [6:0] C_MSTART = 7'b0000011;
    localparam logic [6:0] C_MWAIT  = 7'b0000001;

    typedef struct {
        string       tag;
        bit          side_b;
        logic [6:0]  ctrl;
        logic [15:0] stall;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input string tag, input bit side_b, input logic [6:0] ctrl,
                            input logic [15:0] stall);
        exp_t e;
        e.tag    = tag;
        e.side_b = side_b;
        e.ctrl   = ctrl;
        e.stall  = stall;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [6:0]  oc;
        logic [15:0] os;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.side_b) begin
                oc = {if_b.pc_we, if_b.ifid_en, if_b.ifid_flush, if_b.idex_en,
                      if_b.idex_bubble, if_b.mdu_start, if_b.mdu_busy};
                os = {12'd0, if_b.stall_cycles};
            end else begin
                oc = {if_a.pc_we, if_a.ifid_en, if_a.ifid_flush, if_a.idex_en,
                      if_a.idex_bubble, if_a.mdu_start, if_a.mdu_busy};
                os = if_a.stall_cycles;
            end
            checks++;
            assert (oc === e.ctrl) else begin
                failures++;
                $error("FAIL %s ctrl observed=%b expected=%b", e.tag, oc, e.ctrl);
            end
            checks++;
            assert (os === e.stall) else begin
                failures++;
                $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, os, e.stall);
            end
        end
    endtask

    task automatic drive_a(input logic memread, input logic [4:0] ex_rt, input logic [4:0] rs,
                           input logic [4:0] rt, input logic uses_rt, input logic redirect,
                           input logic rtype, input logic [5:0] funct);
        if_a.ex_memread  = memread;
        if_a.ex_rt       = ex_rt;
        if_a.id_rs       = rs;
        if_a.id_rt       = rt;
        if_a.id_uses_rt  = uses_rt;
        if_a.ex_redirect = redirect;
        if_a.ex_rtype    = rtype;
        if_a.ex_funct    = funct;
    endtask

    task automatic drive_b_lduse(input logic on);
        if_b.ex_memread  = on;
        if_b.ex_rt       = 5'd9;
        if_b.id_rs       = 5'd9;
        if_b.id_rt       = 5'd0;
        if_b.id_uses_rt  = 1'b0;
        if_b.ex_redirect = 1'b0;
        if_b.ex_rtype    = 1'b0;
        if_b.ex_funct    = 6'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        drive_a(0, 0, 0, 0, 0, 0, 0, 6'd0);
        drive_b_lduse(0);

        // reset: two cycles held low, then released
        @(negedge clk);
        push_exp("reset_1", 0, C_RESET, 16'd0);
        push_exp("reset_b", 1, C_RESET, 16'd0);
        check_all();
        @(negedge clk);
        push_exp("reset_2", 0, C_RESET, 16'd0);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        push_exp("run_after_reset", 0, C_RUN, 16'd0);
        check_all();

        // load-use on rs, one bubble
        @(negedge clk);
        drive_a(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 6'd0);
        push_exp("lduse_rs", 0, C_LDUSE, 16'd0);
        check_all();
        @(negedge clk);
        drive_a(0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 6'd0);
        push_exp("lduse_rs_after", 0, C_RUN, 16'd1);
        check_all();
        // ex_rt=0 never stalls
        @(negedge clk);
        drive_a(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 6'd0);
        push_exp("lduse_r0", 0, C_RUN, 16'd1);
        check_all();
        // rt match counts only when rt is a source
        @(negedge clk);
        drive_a(1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 6'd0);
        push_exp("lduse_rt_unused", 0, C_RUN, 16'd1);
        check_all();
        @(negedge clk);
        drive_a(1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 6'd0);
        push_exp("lduse_rt", 0, C_LDUSE, 16'd1);
        check_all();
        // redirect wins over a simultaneous load-use
        @(negedge clk);
        drive_a(1, 5'd5, 5'd5, 5'd0, 0, 1, 0, 6'd0);
        push_exp("redirect", 0, C_REDIR, 16'd2);
        check_all();
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 6'd0);
        push_exp("redirect_after", 0, C_RUN, 16'd2);
        check_all();
        // DIVU funct without R-type is not an MDU op
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 6'h1B);
        push_exp("not_rtype", 0, C_RUN, 16'd2);
        check_all();

        // DIVU: 32 frozen cycles, then release; instruction held in EX while frozen
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            drive_a(1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 6'h1B);
            push_exp(i == 0 ? "divu_start" : "divu_freeze", 0, i == 0 ? C_MSTART : C_MWAIT,
                     16'(2 + i));
            check_all();
        end
        @(negedge clk);
        push_exp("divu_release", 0, C_RUN, 16'd34);
        check_all();
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 6'd0);
        push_exp("divu_no_restart", 0, C_RUN, 16'd34);
        check_all();

        // MULTU interrupted by reset at cycle 10 of the freeze
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_a(0, 0, 0, 0, 0, 0, 1, 6'h19);
            push_exp(i == 0 ? "multu_start" : "multu_freeze", 0, i == 0 ? C_MSTART : C_MWAIT,
                     16'(34 + i));
            check_all();
        end
        @(negedge clk);
        rst = 1'b0;
        push_exp("mdu_reset", 0, C_RESET, 16'd44);
        check_all();
        @(negedge clk);
        rst = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0, 6'd0);
        push_exp("after_mdu_reset", 0, C_RUN, 16'd0);
        check_all();
        @(negedge clk);
        push_exp("after_mdu_reset_2", 0, C_RUN, 16'd0);
        check_all();

        // CNT_W=4 instance: 20 load-use cycles saturate at 15
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive_b_lduse(1);
            push_exp("sat_lduse", 1, C_LDUSE, 16'(i < 15 ? i : 15));
            check_all();
        end
        @(negedge clk);
        drive_b_lduse(0);
        push_exp("sat_hold", 1, C_RUN, 16'd15);
        push_exp("sat_a_idle", 0, C_RUN, 16'd0);
        check_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
